// File: rtl/press_event_decoder.sv
// Classifies debounced button presses as single, double or long and emits one-cycle ticks.
// Optional auto-repeat while held past a long press is built when AUTOREPEAT_EN is defined.
module press_event_decoder #(
  parameter int CLK_DIV   = 50_000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_tick,
  output logic single_tick,
  output logic double_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic busy
);

  localparam int PS_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_MS = (LONG_MS > DCLICK_MS)
                          ? ((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS)
                          : ((DCLICK_MS > REPEAT_MS) ? DCLICK_MS : REPEAT_MS);

  if (((2 ** CNT_W) - 1) < MAX_MS) begin : g_cnt_w_check
    $error("CNT_W too narrow for the longest ms interval");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [PS_W-1:0]   prescaler;
  logic [CNT_W-1:0]  ms_cnt;
  logic              db_q;
  logic              rise, fall, ms_tick;
  logic              restart;
  logic              single_n, double_n, long_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True on the cycle that completes t_ms full milliseconds since the counters last cleared.
  function automatic logic elapsed(input logic tick, input logic [CNT_W-1:0] cnt,
                                   input int t_ms);
    return tick && (cnt == CNT_W'(t_ms - 1));
  endfunction

  assign rise    = db & ~db_q;
  assign fall    = ~db & db_q;
  assign ms_tick = (prescaler == PS_W'(CLK_DIV - 1));

`ifdef AUTOREPEAT_EN
  logic repeat_n;
`endif

  always_comb begin
    state_n  = state;
    single_n = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
`ifdef AUTOREPEAT_EN
    repeat_n = 1'b0;
`endif
    // Edges are tested before timeouts so an edge on the expiry cycle wins.
    case (state)
      IDLE: begin
        if (rise) state_n = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_n = WAIT2;
        end else if (elapsed(ms_tick, ms_cnt, LONG_MS)) begin
          state_n = HELD;
          long_n  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_n = PRESS2;
        end else if (elapsed(ms_tick, ms_cnt, DCLICK_MS)) begin
          state_n  = IDLE;
          single_n = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_n  = IDLE;
          double_n = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_n = IDLE;
        end
`ifdef AUTOREPEAT_EN
        else if (elapsed(ms_tick, ms_cnt, REPEAT_MS)) begin
          repeat_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  assign restart = (state_n != state) | repeat_n;
`else
  assign restart = (state_n != state);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      ms_cnt      <= '0;
      db_q        <= 1'b1;
      press_tick  <= 1'b0;
      single_tick <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      db_q        <= db;
      press_tick  <= rise;
      single_tick <= single_n;
      double_tick <= double_n;
      long_tick   <= long_n;
      busy        <= (state != IDLE);
      if (restart) begin
        prescaler <= '0;
        ms_cnt    <= '0;
      end else begin
        prescaler <= ms_tick ? '0 : prescaler + 1'b1;
        if (ms_tick) ms_cnt <= sat_inc(ms_cnt);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) repeat_tick <= 1'b0;
    else       repeat_tick <= repeat_n;
  end
`else
  assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_press_event_decoder.sv
// Directed bench for press_event_decoder: cycle-accurate reference model plus literal timing checks.
module tb_press_event_decoder;

  localparam int CLK_DIV   = 4;
  localparam int LONG_MS   = 10;
  localparam int DCLICK_MS = 5;
  localparam int REPEAT_MS = 3;
  localparam int CNT_W     = 11;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_HELD = 4;

  logic clk = 1'b0;
  logic reset, db;
  logic press_tick, single_tick, double_tick, long_tick, repeat_tick, busy;

  press_event_decoder #(
    .CLK_DIV(CLK_DIV), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS),
    .REPEAT_MS(REPEAT_MS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .db(db),
    .press_tick(press_tick), .single_tick(single_tick), .double_tick(double_tick),
    .long_tick(long_tick), .repeat_tick(repeat_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the phase and how many cycles have been spent in it.
  int   m_phase = M_IDLE;
  int   m_t = 0;
  logic m_prev = 1'b1;
  logic e_press = 0, e_single = 0, e_double = 0, e_long = 0, e_repeat = 0, e_busy = 0;
  bit   armed = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("press_tick",  press_tick,  e_press);
        chk("single_tick", single_tick, e_single);
        chk("double_tick", double_tick, e_double);
        chk("long_tick",   long_tick,   e_long);
        chk("repeat_tick", repeat_tick, e_repeat);
        chk("busy",        busy,        e_busy);
        chk("event_exclusive",
            ((32'(single_tick) + 32'(double_tick) + 32'(long_tick) + 32'(repeat_tick)) <= 1), 1);
      end
      e_single = 0; e_double = 0; e_long = 0; e_repeat = 0;
      if (reset) begin
        m_phase = M_IDLE; m_t = 0; m_prev = 1'b1;
        e_press = 0; e_busy = 0;
        armed = 1;
      end else begin
        int  nxt;
        bit  r, f;
        r = db && !m_prev;
        f = !db && m_prev;
        e_press = r;
        e_busy  = (m_phase != M_IDLE);
        nxt = m_phase;
        case (m_phase)
          M_IDLE: if (r) nxt = M_P1;
          M_P1: if (f) nxt = M_W2;
                else if (m_t == LONG_MS * CLK_DIV - 1) begin nxt = M_HELD; e_long = 1; end
          M_W2: if (r) nxt = M_P2;
                else if (m_t == DCLICK_MS * CLK_DIV - 1) begin nxt = M_IDLE; e_single = 1; end
          M_P2: if (f) begin nxt = M_IDLE; e_double = 1; end
          M_HELD: if (f) nxt = M_IDLE;
                  else if (AR && ((m_t + 1) % (REPEAT_MS * CLK_DIV) == 0)) e_repeat = 1;
          default: nxt = M_IDLE;
        endcase
        if (nxt != m_phase) m_t = 0;
        else m_t++;
        m_phase = nxt;
        m_prev = db;
      end
    end
  end

  // Per-scenario output log: bit0 press, 1 single, 2 double, 3 long, 4 repeat, 5 busy.
  logic [5:0] lg [0:127];

  function automatic logic db_pat(input int s, input int k);
    case (s)
      1: return k < 20;
      2: return (k < 8) || (k >= 16 && k < 24);
      3: return k < 60;
      4: return k < 70;
      5: return k < 8;
      6: return (k < 16) || (k >= 24 && k < 32);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rst_pat(input int s, input int k);
    return (s == 5 && k == 12) || (s == 6 && k < 4);
  endfunction

  function automatic int cnt_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) n += lg[k][b];
    return n;
  endfunction

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      db = 1'b0; reset = 1'b0;
    end
  endtask

  task automatic run_scen(input int s, input int len);
    for (int k = 0; k < 128; k++) lg[k] = '0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      lg[k] = {busy, repeat_tick, long_tick, double_tick, single_tick, press_tick};
      db    = db_pat(s, k);
      reset = rst_pat(s, k);
    end
    @(posedge clk); #1;
    db = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; db = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_press", press_tick, 0);

    idle_cycles(10);
    run_scen(1, 80);
    chk("s1_press_at1", lg[1][0], 1);
    chk("s1_single_at41", lg[41][1], 1);
    chk("s1_busy_at41", lg[41][5], 1);
    chk("s1_busy_at42", lg[42][5], 0);
    chk("s1_single_count", cnt_bit(1, 0, 79), 1);
    chk("s1_other_ticks", cnt_bit(2, 0, 79) + cnt_bit(3, 0, 79) + cnt_bit(4, 0, 79), 0);

    idle_cycles(10);
    run_scen(2, 60);
    chk("s2_press_at1", lg[1][0], 1);
    chk("s2_press_at17", lg[17][0], 1);
    chk("s2_double_at25", lg[25][2], 1);
    chk("s2_single_count", cnt_bit(1, 0, 59), 0);

    idle_cycles(10);
    run_scen(3, 80);
    chk("s3_long_at41", lg[41][3], 1);
    chk("s3_single_double", cnt_bit(1, 0, 79) + cnt_bit(2, 0, 79), 0);
    chk("s3_busy_at61", lg[61][5], 1);
    chk("s3_busy_at62", lg[62][5], 0);

    idle_cycles(10);
    run_scen(4, 100);
    chk("s4_long_at41", lg[41][3], 1);
`ifdef AUTOREPEAT_EN
    chk("s4_repeat_at53", lg[53][4], 1);
    chk("s4_repeat_at65", lg[65][4], 1);
    chk("s4_repeat_count", cnt_bit(4, 0, 99), 2);
`else
    chk("s4_repeat_count", cnt_bit(4, 0, 99), 0);
`endif

    idle_cycles(10);
    run_scen(5, 60);
    chk("s5_press_at1", lg[1][0], 1);
    chk("s5_busy_at12", lg[12][5], 1);
    chk("s5_busy_at13", lg[13][5], 0);
    chk("s5_single_count", cnt_bit(1, 0, 59), 0);

    idle_cycles(10);
    run_scen(6, 50);
    chk("s6_no_press_held", cnt_bit(0, 0, 23), 0);
    chk("s6_press_at25", lg[25][0], 1);
    chk("s6_busy_before", cnt_bit(5, 0, 24), 0);

    idle_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
